// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: byte FIFO feeding an 8N1 serialiser.
// Registers: DATA (push), STATUS, DIV (cycles per bit).
module mmio_uart_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 434,
  parameter int DIV_W      = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_wren,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_data,
  output logic        o_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       bit_q, bit_d;
  logic [DIV_W-1:0] cyc_q, cyc_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [7:0]       byte_q, byte_d;
  logic             tx_q, tx_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    fcnt_q, fcnt_d;
  logic             ovf_q, ovf_d;
  logic [DIV_W-1:0] div_q, div_d, div_eff;

  logic        full, empty, busy, pop;
  logic        push_req, push_ok, st_clr, div_we;
  logic [31:0] bmask, div_wr, status;
  logic        unused_ok;

  assign full     = (fcnt_q == CW'(FIFO_DEPTH));
  assign empty    = (fcnt_q == '0);
  assign busy     = (state_q != IDLE);
  assign push_req = i_wren && (i_addr == 30'd0) && i_mask[0];
  assign push_ok  = push_req && (!full || pop);
  assign st_clr   = i_wren && (i_addr == 30'd1) && i_mask[0] && i_data[3];
  assign div_we   = i_wren && (i_addr == 30'd2);
  assign div_eff  = (div_q == '0) ? DIV_W'(1) : div_q;

  assign bmask = {{8{i_mask[3]}}, {8{i_mask[2]}},
                  {8{i_mask[1]}}, {8{i_mask[0]}}};
  assign div_wr = (32'(div_q) & ~bmask) | (i_data & bmask);
  assign unused_ok = ^div_wr;

  assign status = {24'd0, 4'(fcnt_q), ovf_q, empty, full, busy};

  always_comb begin
    o_data = '0;
    case (i_addr)
      30'd1:   o_data = status;
      30'd2:   o_data = 32'(div_q);
      default: o_data = '0;
    endcase
  end

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    fcnt_d = fcnt_q;
    ovf_d  = ovf_q;
    div_d  = div_q;
    if (push_ok) wp_d = wp_q + AW'(1);
    if (pop)     rp_d = rp_q + AW'(1);
    if (push_ok && !pop)      fcnt_d = fcnt_q + CW'(1);
    else if (!push_ok && pop) fcnt_d = fcnt_q - CW'(1);
    if (st_clr) ovf_d = 1'b0;
    if (push_req && full && !pop) ovf_d = 1'b1;
    if (div_we) div_d = div_wr[DIV_W-1:0];
  end

  // Frame start: pop head and latch the bit period for the whole frame.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    per_d   = per_q;
    byte_d  = byte_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          byte_d  = mem_q[rp_q];
          per_d   = div_eff;
          cyc_d   = div_eff - DIV_W'(1);
          state_d = START;
        end
      end
      START: begin
        if (cyc_q == '0) begin
          state_d = DATA;
          bit_d   = 3'd0;
          cyc_d   = per_q - DIV_W'(1);
        end else begin
          cyc_d = cyc_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (cyc_q == '0) begin
          cyc_d = per_q - DIV_W'(1);
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cyc_d = cyc_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (cyc_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            byte_d  = mem_q[rp_q];
            per_d   = div_eff;
            cyc_d   = div_eff - DIV_W'(1);
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = byte_d[bit_d];
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wp_q] <= i_data[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      cyc_q   <= '0;
      per_q   <= DIV_W'(1);
      byte_q  <= '0;
      tx_q    <= 1'b1;
      wp_q    <= '0;
      rp_q    <= '0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DIV_W'(DIV_RESET);
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      per_q   <= per_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fcnt_q  <= fcnt_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
    end
  end

  assign o_tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, framing, FIFO
// overflow, byte masks and bit-period changes.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wren = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata;
  logic        tx;

  int checks = 0;
  int failures = 0;
  logic q_tx[$];
  logic q_busy[$];

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .FIFO_DEPTH(8),
    .DIV_RESET(434),
    .DIV_W(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_addr(addr),
    .i_data(wdata),
    .i_wren(wren),
    .i_mask(mask),
    .o_data(rdata),
    .o_tx(tx)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d,
                    input logic [3:0] m);
    addr = a;
    wdata = d;
    mask = m;
    wren = 1'b1;
    tick(1);
    wren = 1'b0;
    mask = '0;
  endtask

  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  // Sample o_tx and busy once per cycle, first sample is the current cycle.
  task automatic record(input int n);
    q_tx.delete();
    q_busy.delete();
    addr = 30'd1;
    #1;
    for (int i = 0; i < n; i++) begin
      q_tx.push_back(tx);
      q_busy.push_back(rdata[0]);
      tick(1);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int p,
                                   input int k);
    int s;
    s = k / p;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[3'(s - 1)];
    return 1'b1;
  endfunction

  task automatic test_reset;
    logic [31:0] d;
    tick(2);
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL por_tx_in_reset got=%b exp=1", tx);
    end
    rst_n = 1'b1;
    tick(2);
    rd(30'd1, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL por_status got=%h exp=%h", d, 32'h4);
    end
    rd(30'd2, d);
    checks++;
    if (d !== 32'd434) begin
      failures++;
      $display("FAIL por_div got=%h exp=%h", d, 32'd434);
    end
  endtask

  task automatic test_single;
    logic [31:0] d;
    int errs;
    int bad;
    wr(30'd2, 32'd4, 4'hF);
    wr(30'd0, 32'hA5, 4'b0001);
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL single_pre_tx got=%b exp=1", tx);
    end
    rd(30'd1, d);
    checks++;
    if (d !== 32'h10) begin
      failures++;
      $display("FAIL single_status_queued got=%h exp=%h", d, 32'h10);
    end
    tick(1);
    record(40);
    errs = 0;
    bad = -1;
    for (int k = 0; k < 40; k++)
      if (q_tx[k] !== exp_bit(8'hA5, 4, k)) begin
        errs++;
        if (bad < 0) bad = k;
      end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL single_frame errs=%0d first_cycle=%0d exp=0", errs, bad);
    end
    errs = 0;
    for (int k = 0; k < 40; k++)
      if (q_busy[k] !== 1'b1) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL single_busy idle_cycles=%0d exp=0", errs);
    end
    rd(30'd1, d);
    checks++;
    if (d !== 32'h4 || tx !== 1'b1) begin
      failures++;
      $display("FAIL single_after status=%h tx=%b exp=4/1", d, tx);
    end
  endtask

  task automatic test_back_to_back;
    int errs;
    logic e;
    wr(30'd2, 32'd2, 4'hF);
    wr(30'd0, 32'h55, 4'b0001);
    wr(30'd0, 32'h0F, 4'b0001);
    record(44);
    errs = 0;
    for (int k = 0; k < 44; k++) begin
      if (k < 20)      e = exp_bit(8'h55, 2, k);
      else if (k < 40) e = exp_bit(8'h0F, 2, k - 20);
      else             e = 1'b1;
      if (q_tx[k] !== e) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL back_to_back_frames errs=%0d exp=0", errs);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    int errs;
    int f;
    logic e;
    wr(30'd2, 32'd100, 4'hF);
    for (int i = 0; i < 10; i++)
      wr(30'd0, 32'h31 + 32'(i), 4'b0001);
    rd(30'd1, d);
    checks++;
    if (d !== 32'h8B) begin
      failures++;
      $display("FAIL ovf_status_full got=%h exp=%h", d, 32'h8B);
    end
    wr(30'd1, 32'h8, 4'b0001);
    rd(30'd1, d);
    checks++;
    if (d !== 32'h83) begin
      failures++;
      $display("FAIL ovf_clear got=%h exp=%h", d, 32'h83);
    end
    record(9005);
    errs = 0;
    for (int j = 0; j < 9005; j++) begin
      f = (j + 9) / 1000;
      if (f < 9) e = exp_bit(8'(8'h31 + f), 100, (j + 9) % 1000);
      else       e = 1'b1;
      if (q_tx[j] !== e) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL ovf_sequence errs=%0d exp=0", errs);
    end
    rd(30'd1, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL ovf_drained got=%h exp=%h", d, 32'h4);
    end
  endtask

  task automatic test_mask_decode;
    logic [31:0] d;
    wr(30'd0, 32'h77, 4'b1110);
    rd(30'd1, d);
    tick(3);
    checks++;
    if (d !== 32'h4 || tx !== 1'b1) begin
      failures++;
      $display("FAIL data_mask_nopush status=%h tx=%b exp=4/1", d, tx);
    end
    wr(30'd2, 32'hFFFF_1234, 4'b0001);
    rd(30'd2, d);
    checks++;
    if (d !== 32'h34) begin
      failures++;
      $display("FAIL div_lane0 got=%h exp=%h", d, 32'h34);
    end
    wr(30'd2, 32'hFFFF_AB00, 4'b0010);
    rd(30'd2, d);
    checks++;
    if (d !== 32'hAB34) begin
      failures++;
      $display("FAIL div_lane1 got=%h exp=%h", d, 32'hAB34);
    end
    wr(30'd2, 32'hFFFF_FFFF, 4'hF);
    rd(30'd2, d);
    checks++;
    if (d !== 32'hFFFF) begin
      failures++;
      $display("FAIL div_upper_zero got=%h exp=%h", d, 32'hFFFF);
    end
    wr(30'd3, 32'hFFFF_FFFF, 4'hF);
    rd(30'd2, d);
    checks++;
    if (d !== 32'hFFFF) begin
      failures++;
      $display("FAIL off3_write_ignored div=%h exp=%h", d, 32'hFFFF);
    end
    rd(30'd5, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL read_off5 got=%h exp=0", d);
    end
    rd(30'd0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL read_data_reg got=%h exp=0", d);
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] d;
    int errs;
    logic e;
    wr(30'd2, 32'd0, 4'hF);
    rd(30'd2, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL div_zero_read got=%h exp=0", d);
    end
    wr(30'd0, 32'h3C, 4'b0001);
    tick(1);
    record(12);
    errs = 0;
    for (int k = 0; k < 12; k++) begin
      e = (k < 10) ? exp_bit(8'h3C, 1, k) : 1'b1;
      if (q_tx[k] !== e) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL div_zero_frame errs=%0d exp=0", errs);
    end
  endtask

  task automatic test_div_change;
    int errs;
    int k;
    logic e;
    wr(30'd2, 32'd8, 4'hF);
    wr(30'd0, 32'hC3, 4'b0001);
    wr(30'd0, 32'h5A, 4'b0001);
    tick(20);
    wr(30'd2, 32'd3, 4'hF);
    record(115);
    errs = 0;
    for (int j = 0; j < 115; j++) begin
      k = j + 21;
      if (k < 80)       e = exp_bit(8'hC3, 8, k);
      else if (k < 110) e = exp_bit(8'h5A, 3, k - 80);
      else              e = 1'b1;
      if (q_tx[j] !== e) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL div_change_frames errs=%0d exp=0", errs);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    wr(30'd2, 32'd4, 4'hF);
    wr(30'd0, 32'h00, 4'b0001);
    wr(30'd0, 32'hFF, 4'b0001);
    tick(5);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL mid_frame_low got=%b exp=0", tx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_tx got=%b exp=1", tx);
    end
    rd(30'd1, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL reset_status got=%h exp=%h", d, 32'h4);
    end
    rd(30'd2, d);
    checks++;
    if (d !== 32'd434) begin
      failures++;
      $display("FAIL reset_div got=%h exp=%h", d, 32'd434);
    end
    rst_n = 1'b1;
    tick(3);
    rd(30'd1, d);
    checks++;
    if (d !== 32'h4 || tx !== 1'b1) begin
      failures++;
      $display("FAIL post_reset status=%h tx=%b exp=4/1", d, tx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_mask_decode();
    test_div_zero();
    test_div_change();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the MMIO port of the data-memory crossbar.
- Consumes the crossbar's MMIO-side address, data, write enable and byte mask.
- Returns the read data that the crossbar muxes back to the CPU in the same cycle.
- Buffers CPU-written bytes in a small FIFO and serialises them as 8N1 frames on o_tx at a programmable bit period.

Parameters:
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..8.
- DIV_RESET, 434: reset value of the DIV register, in clock cycles per bit.
- DIV_W, 16: width of the DIV register.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_addr  input  30  word offset within the MMIO region, already rebased by the crossbar.
- i_data  input  32  write data.
- i_wren  input  1  write strobe, one transfer per cycle while high.
- i_mask  input  4  byte enables for writes.
- o_data  output  32  read data, combinational from i_addr.
- o_tx  output  1  serial line, idle high.

Behaviour:
- Register map (word offsets):
  - 0 DATA: a write with i_mask[0]=1 pushes i_data[7:0]; reads return 0.
  - 1 STATUS, read: bit0 busy (FSM not IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky), bits[7:4] fifo_count, rest 0. Write: i_mask[0]=1 with i_data[3]=1 clears overflow; other bits ignored.
  - 2 DIV: R/W, occupies bits[DIV_W-1:0]. Each byte lane is written only where its i_mask bit is set; bits above DIV_W read 0.
  - Offset >=3: reads 0, writes ignored.
- Reads: purely combinational, zero latency, no side effects. Reading is allowed every cycle.
- Writes: take effect at the rising edge where i_wren=1.
- FIFO push/pop:
  - Push to a full FIFO: byte dropped, overflow set.
  - Push and pop in the same cycle: both happen, count unchanged. A push while full is accepted if a pop occurs in that cycle, and overflow is not set.
- Bit period P = DIV latched at frame start; DIV=0 is treated as 1. A DIV write mid-frame affects only the next frame.
- FSM states IDLE, START, DATA, STOP; bit counter 0..7; cycle counter counts P-1 down to 0.
  - IDLE: o_tx=1. If the FIFO is non-empty, pop the head, latch byte and P, go to START.
  - START: o_tx=0 for P cycles, then DATA with bit index 0.
  - DATA: o_tx=byte[idx] for P cycles each, LSB first; after idx 7 go to STOP.
  - STOP: o_tx=1 for P cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); else go to IDLE.
- Frame length: exactly 10*P cycles.
- Latency: a push into an empty FIFO while IDLE shows o_tx falling 2 edges after the write edge (one edge to push, one edge to pop and enter START).
- Reset (asynchronous, any time including mid-frame):
  - o_tx=1, FSM to IDLE.
  - FIFO empty (count 0), overflow 0, DIV=DIV_RESET.
  - o_data then reflects reset register values (STATUS reads 0x4).
- o_tx is registered: no combinational path from bus inputs to o_tx.

Test Plan:
- Reset: assert i_rst_n=0 mid-frame -> o_tx=1 immediately. After release, STATUS reads 0x00000004 and DIV reads DIV_RESET.
- Single byte: write DIV=4, then DATA=0xA5 with mask 4'b0001 -> o_tx low 2 edges after the DATA write. Bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, 40 cycles total. busy=1 throughout the frame, 0 after.
- Back-to-back: DIV=2, push 0x55 and 0x0F on consecutive cycles -> two contiguous 20-cycle frames, no idle cycle between the stop bit and the next start bit.
- Overflow: DIV=100, push 10 bytes rapidly -> first byte popped, FIFO fills to 8, count=8, full=1. 10th push dropped, overflow=1. Writing STATUS=0x8 clears overflow; transmitted sequence is bytes 1..9.
- Masks and decode:
  - DATA write with mask 4'b1110 -> no push.
  - DIV write 0xFFFF_1234 with mask 4'b0001 -> DIV low byte = 0x34, upper byte unchanged.
  - Read offset 5 -> 0.
  - DIV=0 -> 10-cycle frames.
- DIV change mid-frame: DIV=8, start a frame, write DIV=3 during DATA -> current frame remains 80 cycles, next frame 30 cycles.
